// File: rtl/in_fea_pingpong_buf_pkg.sv
// Shared constants and read-FSM encoding for the input-feature ping-pong buffer.
package in_fea_pingpong_buf_pkg;

  localparam int DATA_W      = 400;
  localparam int BANK_DEPTH  = 75;
  localparam int ADDR_W      = 7;
  localparam int HALT_MARGIN = 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);
  localparam logic [ADDR_W-1:0] HALT_LVL  = ADDR_W'(BANK_DEPTH - HALT_MARGIN);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/in_fea_pingpong_buf_ram.sv
// Single-bank simple dual-port RAM (ppbuf_bank_ram) with a registered read port.
module ppbuf_bank_ram
  import in_fea_pingpong_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [BANK_DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // read port register; cleared by reset so the buffer output starts at zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/in_fea_pingpong_buf.sv
// Two-bank ping-pong buffer between the input-feature loader and the conv PE array.
// Optional partial-bank flush port enabled by defining INFEA_PPBUF_FLUSH_EN.
module in_fea_pingpong_buf
  import in_fea_pingpong_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_v,
  input  logic [DATA_W-1:0] wr_data,
  output logic              halt,
  input  logic              rd_req,
  output logic              rd_v,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        bank_rdy,
  output logic              ovf
`ifdef INFEA_PPBUF_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  logic              wr_bank_r, wr_bank_n;
  logic [ADDR_W-1:0] wr_cnt_r, wr_cnt_n;
  logic [1:0]        bank_rdy_r, bank_rdy_n;
  logic              halt_r, halt_n;
  logic              ovf_r;
  rd_state_e         rd_state_r, rd_state_n;
  logic              rd_bank_r, rd_bank_n;
  logic [ADDR_W-1:0] rd_cnt_r, rd_cnt_n;
  logic              rd_v_r, rd_last_r, rd_sel_r;
  logic              wr_ok_s, wr_drop_s, close_s;
  logic              rd_issue_s, rd_end_s;
  logic [ADDR_W-1:0] rd_last_addr_s;
  logic [DATA_W-1:0] rdata0_s, rdata1_s;

`ifdef INFEA_PPBUF_FLUSH_EN
  logic [ADDR_W-1:0] last_addr_r [2];
  logic [ADDR_W-1:0] close_last_s;
  logic              flush_take_s;
`endif

  // write acceptance, bank close (full or flushed) and read issue
  always_comb begin
    wr_ok_s    = wr_v && !bank_rdy_r[wr_bank_r];
    wr_drop_s  = wr_v && bank_rdy_r[wr_bank_r];
    rd_issue_s = (rd_state_r == R_READ) && rd_req;
`ifdef INFEA_PPBUF_FLUSH_EN
    // a flush closes the bank at the last vector written, including a coincident write
    flush_take_s   = flush && !bank_rdy_r[wr_bank_r] && (wr_ok_s || (wr_cnt_r != '0));
    close_s        = (wr_ok_s && (wr_cnt_r == LAST_ADDR)) || flush_take_s;
    close_last_s   = wr_ok_s ? wr_cnt_r : (wr_cnt_r - ADDR_ONE);
    rd_last_addr_s = last_addr_r[rd_bank_r];
`else
    close_s        = wr_ok_s && (wr_cnt_r == LAST_ADDR);
    rd_last_addr_s = LAST_ADDR;
`endif
    rd_end_s = rd_issue_s && (rd_cnt_r == rd_last_addr_s);
  end

  // next write pointer, bank flags and halt (halt tracks the post-update state)
  always_comb begin
    wr_bank_n  = wr_bank_r;
    wr_cnt_n   = wr_cnt_r;
    bank_rdy_n = bank_rdy_r;
    if (close_s) begin
      wr_bank_n             = ~wr_bank_r;
      wr_cnt_n              = '0;
      bank_rdy_n[wr_bank_r] = 1'b1;
    end else if (wr_ok_s) begin
      wr_cnt_n = wr_cnt_r + ADDR_ONE;
    end else begin
      wr_cnt_n = wr_cnt_r;
    end
    if (rd_end_s) begin
      bank_rdy_n[rd_bank_r] = 1'b0;
    end else begin
      bank_rdy_n[rd_bank_r] = bank_rdy_n[rd_bank_r];
    end
    halt_n = bank_rdy_n[wr_bank_n] ||
             (bank_rdy_n[~wr_bank_n] && (wr_cnt_n >= HALT_LVL));
  end

  // read FSM next state
  always_comb begin
    rd_state_n = rd_state_r;
    rd_bank_n  = rd_bank_r;
    rd_cnt_n   = rd_cnt_r;
    case (rd_state_r)
      R_IDLE: begin
        if (bank_rdy_r[rd_bank_r]) begin
          rd_state_n = R_READ;
          rd_cnt_n   = '0;
        end else begin
          rd_state_n = R_IDLE;
        end
      end
      R_READ: begin
        if (rd_end_s) begin
          rd_state_n = R_IDLE;
          rd_cnt_n   = '0;
          rd_bank_n  = ~rd_bank_r;
        end else if (rd_issue_s) begin
          rd_cnt_n = rd_cnt_r + ADDR_ONE;
        end else begin
          rd_cnt_n = rd_cnt_r;
        end
      end
      default: begin
        rd_state_n = R_IDLE;
        rd_cnt_n   = '0;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank_r  <= 1'b0;
      wr_cnt_r   <= '0;
      bank_rdy_r <= 2'b00;
      halt_r     <= 1'b0;
      ovf_r      <= 1'b0;
      rd_state_r <= R_IDLE;
      rd_bank_r  <= 1'b0;
      rd_cnt_r   <= '0;
      rd_v_r     <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_sel_r   <= 1'b0;
    end else begin
      wr_bank_r  <= wr_bank_n;
      wr_cnt_r   <= wr_cnt_n;
      bank_rdy_r <= bank_rdy_n;
      halt_r     <= halt_n;
      ovf_r      <= ovf_r | wr_drop_s;
      rd_state_r <= rd_state_n;
      rd_bank_r  <= rd_bank_n;
      rd_cnt_r   <= rd_cnt_n;
      rd_v_r     <= rd_issue_s;
      rd_last_r  <= rd_end_s;
      rd_sel_r   <= rd_issue_s ? rd_bank_r : rd_sel_r;
    end
  end

`ifdef INFEA_PPBUF_FLUSH_EN
  // per-bank last valid address, recorded when the bank is closed
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_addr_r[0] <= LAST_ADDR;
      last_addr_r[1] <= LAST_ADDR;
    end else if (close_s) begin
      last_addr_r[wr_bank_r] <= close_last_s;
    end
  end
`endif

  ppbuf_bank_ram u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok_s && (wr_bank_r == 1'b0)),
    .waddr (wr_cnt_r),
    .wdata (wr_data),
    .re    (rd_issue_s && (rd_bank_r == 1'b0)),
    .raddr (rd_cnt_r),
    .rdata (rdata0_s)
  );

  ppbuf_bank_ram u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok_s && (wr_bank_r == 1'b1)),
    .waddr (wr_cnt_r),
    .wdata (wr_data),
    .re    (rd_issue_s && (rd_bank_r == 1'b1)),
    .raddr (rd_cnt_r),
    .rdata (rdata1_s)
  );

  assign halt     = halt_r;
  assign ovf      = ovf_r;
  assign bank_rdy = bank_rdy_r;
  assign rd_v     = rd_v_r;
  assign rd_last  = rd_last_r;
  assign rd_data  = rd_sel_r ? rdata1_s : rdata0_s;

endmodule
